led_effect_scheduler: RTL and testbench

Sequencer for the 8-LED panel. It generates the step rate from the board clock and plays two effects: a bar fill from the MSB and a single running dot. It plays them singly or alternately, for a programmed number of cycles with a blank pause between cycles. It replaces hand-stepping the LED pattern FSM from a switch and exposes a start/stop/busy/done control interface to the top level.

---
 rtl/led_sched_pkg.sv | 35 +++
 rtl/led_effect_scheduler_tick_gen.sv | 38 +++
 rtl/led_effect_scheduler.sv | 146 ++++++++++++++
 tb/tb_led_effect_scheduler.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/led_sched_pkg.sv
// Shared types and pattern helpers for the LED effect scheduler.
package led_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DOT   = 2'd2,
    PAUSE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_FILL     = 2'b00,
    MODE_DOT      = 2'b01,
    MODE_FILL_DOT = 2'b10,
    MODE_DOT_FILL = 2'b11
  } mode_e;

  // Top k+1 bits set: 80, C0, E0 ... FF.
  function automatic logic [7:0] fill_pat(input logic [2:0] k);
    return 8'hFF << (3'd7 - k);
  endfunction

  function automatic logic [7:0] dot_pat(input logic [2:0] k);
    return 8'h80 >> k;
  endfunction

  function automatic state_e first_effect(input mode_e m);
    return (m == MODE_DOT || m == MODE_DOT_FILL) ? DOT : FILL;
  endfunction

  function automatic logic is_alternating(input mode_e m);
    return (m == MODE_FILL_DOT) || (m == MODE_DOT_FILL);
  endfunction

endpackage

// File: rtl/led_effect_scheduler_tick_gen.sv
// Step-rate prescaler: one-cycle tick every PRESCALE enabled clocks.
module led_tick_gen #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic ck,
  input  logic rs,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  // NOTE: next-state defaults come first so every path assigns cnt_d and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge ck) begin
    if (!rs) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_effect_scheduler.sv
// Plays fill/dot LED effects singly or alternately for a set number of cycles with blank pauses.
module led_effect_scheduler
  import led_sched_pkg::*;
#(
  parameter int unsigned PRESCALE    = 4,
  parameter int unsigned PAUSE_TICKS = 2
) (
  input  logic       ck,
  input  logic       rs,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] mode,
  input  logic [3:0] reps,
  output logic [7:0] led,
  output logic       busy,
  output logic       done,
  output logic       tick
);

  localparam int unsigned PW = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;
  localparam logic [PW-1:0] PAUSE_LAST = PW'((PAUSE_TICKS > 0) ? PAUSE_TICKS - 1 : 0);

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [2:0]    k_q, k_d;
  logic [3:0]    rem_q, rem_d;
  logic          cont_q, cont_d;
  logic          phase_q, phase_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [7:0]    led_q, led_d;
  logic          done_q, done_d;
  logic          start_acc;

  led_tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .ck   (ck),
    .rs   (rs),
    .en   (busy),
    .clr  (start_acc),
    .tick (tick)
  );

  assign busy = (state_q != IDLE);
  assign led  = led_q;
  assign done = done_q;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    k_d       = k_q;
    rem_d     = rem_q;
    cont_d    = cont_q;
    phase_d   = phase_q;
    pcnt_d    = pcnt_q;
    led_d     = led_q;
    done_d    = 1'b0;
    start_acc = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          start_acc = 1'b1;
          mode_d    = mode_e'(mode);
          rem_d     = reps;
          cont_d    = (reps == 4'd0);
          phase_d   = 1'b0;
          k_d       = 3'd0;
          state_d   = first_effect(mode_e'(mode));
          led_d     = 8'h80;
        end
      end

      FILL, DOT: begin
        if (stop) begin
          state_d = IDLE;
          led_d   = 8'h00;
        end else if (tick) begin
          if (k_q != 3'd7) begin
            k_d   = k_q + 3'd1;
            led_d = (state_q == FILL) ? fill_pat(k_q + 3'd1) : dot_pat(k_q + 3'd1);
          end else if (is_alternating(mode_q) && !phase_q) begin
            phase_d = 1'b1;
            k_d     = 3'd0;
            state_d = (state_q == FILL) ? DOT : FILL;
            led_d   = 8'h80;
          end else if (!cont_q && rem_q == 4'd1) begin
            state_d = IDLE;
            led_d   = 8'h00;
            done_d  = 1'b1;
          end else begin
            if (!cont_q) rem_d = rem_q - 4'd1;
            phase_d = 1'b0;
            k_d     = 3'd0;
            pcnt_d  = '0;
            if (PAUSE_TICKS == 0) begin
              state_d = first_effect(mode_q);
              led_d   = 8'h80;
            end else begin
              state_d = PAUSE;
              led_d   = 8'h00;
            end
          end
        end
      end

      PAUSE: begin
        if (stop) begin
          state_d = IDLE;
          led_d   = 8'h00;
        end else if (tick) begin
          if (pcnt_q == PAUSE_LAST) begin
            state_d = first_effect(mode_q);
            k_d     = 3'd0;
            led_d   = 8'h80;
          end else begin
            pcnt_d = pcnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge ck) begin
    if (!rs) begin
      state_q <= IDLE;
      mode_q  <= MODE_FILL;
      k_q     <= 3'd0;
      rem_q   <= 4'd0;
      cont_q  <= 1'b0;
      phase_q <= 1'b0;
      pcnt_q  <= '0;
      led_q   <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      k_q     <= k_d;
      rem_q   <= rem_d;
      cont_q  <= cont_d;
      phase_q <= phase_d;
      pcnt_q  <= pcnt_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_led_effect_scheduler.sv
// Scoreboard bench: expected per-cycle led/busy/done/tick traces are queued, then compared at negedge.
module tb_led_effect_scheduler;

  localparam int P  = 4;
  localparam int PT = 2;

  typedef struct {
    logic [7:0] led;
    logic       busy;
    logic       done;
    logic       tick;
  } exp_t;

  logic       ck = 1'b0;
  logic       rs, start, stop;
  logic [1:0] mode;
  logic [3:0] reps;
  logic [7:0] led;
  logic       busy, done, tick;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 ck = ~ck;

  led_effect_scheduler #(.PRESCALE(P), .PAUSE_TICKS(PT)) dut (
    .ck    (ck),
    .rs    (rs),
    .start (start),
    .stop  (stop),
    .mode  (mode),
    .reps  (reps),
    .led   (led),
    .busy  (busy),
    .done  (done),
    .tick  (tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [7:0] l, input logic b, input logic d, input logic t);
    exp_t e;
    e.led = l; e.busy = b; e.done = d; e.tick = t;
    exp_q.push_back(e);
  endtask

  task automatic push_effect(input bit is_dot);
    logic [7:0] low, pat;
    for (int s = 0; s < 8; s++) begin
      low = 8'hFF >> (s + 1);
      pat = is_dot ? (8'h80 >> s) : ~low;
      for (int c = 0; c < P; c++) push(pat, 1'b1, 1'b0, c == P - 1);
    end
  endtask

  task automatic push_cycle(input logic [1:0] m);
    push_effect(m[0]);
    if (m[1]) push_effect(!m[0]);
  endtask

  task automatic push_pause();
    for (int c = 0; c < P * PT; c++) push(8'h00, 1'b1, 1'b0, (c % P) == P - 1);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_done();
    push(8'h00, 1'b0, 1'b1, 1'b0);
    push_idle(1);
  endtask

  task automatic drain(input int n, input string name);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge ck);
      if (exp_q.size() == 0) begin
        check($sformatf("%s[%0d].queue_underflow", name, i), 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s[%0d].led", name, i), {24'd0, led}, {24'd0, e.led});
        check($sformatf("%s[%0d].busy", name, i), {31'd0, busy}, {31'd0, e.busy});
        check($sformatf("%s[%0d].done", name, i), {31'd0, done}, {31'd0, e.done});
        check($sformatf("%s[%0d].tick", name, i), {31'd0, tick}, {31'd0, e.tick});
      end
    end
  endtask

  task automatic launch(input logic [1:0] m, input logic [3:0] r);
    mode  = m;
    reps  = r;
    start = 1'b1;
  endtask

  initial begin
    // 1: reset held with start asserted
    rs = 1'b0; start = 1'b1; stop = 1'b0; mode = 2'b00; reps = 4'd1;
    push_idle(2);
    drain(2, "reset");
    rs = 1'b1; start = 1'b0;
    push_idle(2);
    drain(2, "post_reset");

    // 2: fill only, one cycle
    launch(2'b00, 4'd1);
    push_cycle(2'b00); push_done();
    drain(1, "fill1");
    start = 1'b0;
    drain(exp_q.size(), "fill1");

    // 3: fill then dot, two cycles with pause between
    launch(2'b10, 4'd2);
    push_cycle(2'b10); push_pause(); push_cycle(2'b10); push_done();
    drain(1, "filldot2");
    start = 1'b0;
    drain(exp_q.size(), "filldot2");

    // 4: dot continuous, stopped at step 3 of the seventh cycle
    launch(2'b01, 4'd0);
    for (int c = 0; c < 6; c++) begin
      push_cycle(2'b01); push_pause();
    end
    push_effect(1'b1);
    repeat (32 - (3 * P + 2)) void'(exp_q.pop_back());
    drain(1, "dot_cont");
    start = 1'b0;
    drain(exp_q.size(), "dot_cont");
    check("stop_point_led", {24'd0, led}, 32'h10);
    stop = 1'b1;
    push_idle(1);
    drain(1, "stop");
    stop = 1'b0;
    push_idle(3);
    drain(3, "stop_after");

    // 5: start while busy with new mode/reps is ignored; start+stop in IDLE stays idle
    launch(2'b00, 4'd1);
    push_cycle(2'b00); push_done();
    drain(1, "busy_start");
    start = 1'b0;
    drain(2 * P, "busy_start");
    check("busy_start_led", {24'd0, led}, 32'hE0);
    launch(2'b01, 4'd3);
    drain(1, "busy_start");
    start = 1'b0;
    drain(exp_q.size(), "busy_start");
    start = 1'b1; stop = 1'b1;
    push_idle(3);
    drain(1, "start_stop");
    start = 1'b0;
    drain(2, "start_stop");
    stop = 1'b0;
    push_idle(2);
    drain(2, "start_stop_after");

    // 6: reset during dot step 5, then a fresh run
    launch(2'b01, 4'd0);
    push_effect(1'b1);
    drain(1, "dot_rst");
    start = 1'b0;
    drain(5 * P, "dot_rst");
    check("rst_point_led", {24'd0, led}, 32'h04);
    rs = 1'b0;
    exp_q.delete();
    push_idle(1);
    drain(1, "mid_reset");
    rs = 1'b1;
    push_idle(2);
    drain(2, "mid_reset_after");
    launch(2'b01, 4'd1);
    push_cycle(2'b01); push_done();
    drain(1, "fresh");
    start = 1'b0;
    drain(exp_q.size(), "fresh");

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
